// File: rtl/tape_driver_if.sv
// tape_driver_if: command, tape and status signals between tape_driver and its host/tape.
interface tape_driver_if #(parameter int HEAD_W = 3) ();
  localparam int N = 2 ** HEAD_W;
  logic              start;
  logic [1:0]        op;
  logic [1:0]        rd_data;
  logic              mode;
  logic [HEAD_W-1:0] head;
  logic              tape_clr;
  logic [1:0]        wr_data;
  logic              busy;
  logic              done;
  logic [N-1:0]      result;
  logic              overflow;
  modport master (
    input  start, op, rd_data,
    output mode, head, tape_clr, wr_data, busy, done, result, overflow
  );
  modport slave (
    output start, op, rd_data,
    input  mode, head, tape_clr, wr_data, busy, done, result, overflow
  );
endinterface

// File: rtl/tape_driver.sv
// tape_driver: sequences CLEAR / INCR / DUMP / NOP commands over an N-cell 2-bit symbol tape.
module tape_driver #(parameter int HEAD_W = 3) (
  input logic           clk,
  input logic           reset,
  tape_driver_if.master tp
);
  localparam int N = 2 ** HEAD_W;
  localparam logic [1:0] OP_CLR = 2'b00, OP_INCR = 2'b01, OP_DUMP = 2'b10, OP_NOP = 2'b11;
  typedef enum logic [2:0] {IDLE, CLR, RD_REQ, RD_WAIT, WR, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [1:0]        sym_q, sym_d;
  logic [N-1:0]      result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              last;
  assign last = head_q == HEAD_W'(N - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      head_q   <= '0;
      sym_q    <= 2'b00;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      head_q   <= head_d;
      sym_q    <= sym_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    head_d   = head_q;
    sym_d    = sym_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (tp.start) begin
        op_d    = tp.op;
        head_d  = '0;
        ovf_d   = tp.op[1] ? ovf_q : 1'b0;
        state_d = tp.op == OP_CLR ? CLR : tp.op == OP_NOP ? DONE : RD_REQ;
      end
      CLR: begin
        head_d  = last ? head_q : head_q + 1'b1;
        state_d = last ? DONE : CLR;
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        sym_d = tp.rd_data;
        if (op_q == OP_DUMP) begin
          result_d[head_q] = tp.rd_data[0];
          head_d           = last ? head_q : head_q + 1'b1;
          state_d          = last ? DONE : RD_REQ;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        // a one becomes zero and carries into the next cell; anything else absorbs the carry
        ovf_d   = sym_q == 2'b01 && last ? 1'b1 : ovf_q;
        head_d  = sym_q == 2'b01 && !last ? head_q + 1'b1 : head_q;
        state_d = sym_q == 2'b01 && !last ? RD_REQ : DONE;
      end
      DONE: begin
        head_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // write strobes are gated by reset so an aborting edge never commits a tape write
  assign tp.mode     = reset && (state_q == CLR || state_q == WR);
  assign tp.tape_clr = reset && state_q == CLR;
  assign tp.wr_data  = state_q == WR && sym_q != 2'b01 ? 2'b01 : 2'b00;
  assign tp.head     = head_q;
  assign tp.busy     = state_q != IDLE;
  assign tp.done     = state_q == DONE;
  assign tp.result   = result_q;
  assign tp.overflow = ovf_q;
endmodule
